// File: rtl/mem_access_stage.sv
// MEM pipeline stage. It sits between the EX/MEM register and writeback.
// It runs a req/ack handshake with a variable-latency data memory and holds
// the MEM/WB register for the writeback stage.
// Each access walks through IDLE -> REQ -> DONE. The upstream pipe is frozen
// for the IDLE cycle that launches the access and for every REQ cycle.
// In DONE the op that is still held in EX/MEM retires without being reissued.
// Optional feature macro: MEM_STAGE_STATS_EN adds saturating counters for
// completed accesses and stall cycles. When it is undefined, both outputs
// are tied to 0.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [STAT_W-1:0] stat_access,
  output logic [STAT_W-1:0] stat_stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;   // load data captured on ack
  logic [1:0]        wb_q, wb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              stall_c;

  // Next-state logic: handshake sequencing, stall and MEM/WB fill.
  // A stalled cycle loads a bubble, so the MEM/WB fields default to 0.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    wb_d    = '0;
    rdata_d = '0;
    alu_d   = '0;
    rd_d    = '0;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          // When both request bits are set, the op is treated as a write.
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = alu_in;
          wdata_d = wdata_in;
          state_d = S_REQ;
        end else begin
          wb_d  = wb_in;
          alu_d = alu_in;
          rd_d  = rd_in;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          data_d  = we_q ? '0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The op is still in EX/MEM. It retires here with the captured data.
        wb_d    = wb_in;
        alu_d   = alu_in;
        rd_d    = rd_in;
        rdata_d = data_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset clears everything, including an open access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign stall      = stall_c;
  assign wb_out     = wb_q;
  assign rdata_out  = rdata_q;
  assign alu_out    = alu_q;
  assign rd_out     = rd_q;

`ifdef MEM_STAGE_STATS_EN
  logic [STAT_W-1:0] acc_q, stl_q;

  // Saturating counters for acked accesses and stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      stl_q <= '0;
    end else begin
      if ((state_q == S_REQ) && dmem_ack && !(&acc_q)) acc_q <= acc_q + 1'b1;
      if (stall_c && !(&stl_q))                        stl_q <= stl_q + 1'b1;
    end
  end

  assign stat_access = acc_q;
  assign stat_stall  = stl_q;
`else
  assign stat_access = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. It contains an op-level reference model.
// Each op is predicted from its kind and its memory latency: how many cycles
// it stalls, the dmem request it issues, and the MEM/WB value it finally
// retires. A small associative-array memory supplies the expected load data.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic        mem_read, mem_write;
  logic [31:0] alu_in, wdata_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [1:0]  wb_out;
  logic [31:0] rdata_out, alu_out;
  logic [4:0]  rd_out;
  logic [31:0] stat_access, stat_stall;

  int n_chk = 0;
  int n_err = 0;
  int exp_acc = 0;
  int exp_stl = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .mem_read(mem_read), .mem_write(mem_write),
    .alu_in(alu_in), .wdata_in(wdata_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_out(wb_out), .rdata_out(rdata_out), .alu_out(alu_out), .rd_out(rd_out),
    .stat_access(stat_access), .stat_stall(stat_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_mwb(input string tag, input logic [1:0] wb, input logic [31:0] rdat,
                           input logic [31:0] alu, input logic [4:0] rd);
    check({tag, "_wb"}, 64'(wb_out), 64'(wb));
    check({tag, "_rdata"}, 64'(rdata_out), 64'(rdat));
    check({tag, "_alu"}, 64'(alu_out), 64'(alu));
    check({tag, "_rd"}, 64'(rd_out), 64'(rd));
  endtask

  task automatic check_stats(input string tag);
`ifdef MEM_STAGE_STATS_EN
    check({tag, "_stat_acc"}, 64'(stat_access), 64'(exp_acc));
    check({tag, "_stat_stl"}, 64'(stat_stall), 64'(exp_stl));
`else
    check({tag, "_stat_acc"}, 64'(stat_access), 64'd0);
    check({tag, "_stat_stl"}, 64'(stat_stall), 64'd0);
`endif
  endtask

  // Present one op in EX/MEM and follow it until it retires. lat is the
  // number of REQ cycles without an ack before the acked REQ cycle.
  task automatic run_op(input logic rq, input logic wq, input logic [1:0] wb,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input int lat);
    logic [31:0] exp_rd;
    wb_in = wb; mem_read = rq; mem_write = wq; alu_in = alu; wdata_in = wd; rd_in = rd;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    if (!(rq | wq)) begin
      check("nop_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      check_mwb("nop", wb, 32'd0, alu, rd);
      check_stats("nop");
      return;
    end
    check("idle_stall", 64'(stall), 64'd1);
    check("idle_req", 64'(dmem_req), 64'd0);
    exp_stl++;
    @(posedge clk); #1;
    check_mwb("launch_bubble", 2'd0, 32'd0, 32'd0, 5'd0);
    exp_rd = wq ? 32'd0 : memrd(alu);
    for (int w = 0; w <= lat; w++) begin
      dmem_ack   = (w == lat);
      dmem_rdata = (w == lat) ? memrd(alu) : $urandom;
      #1;
      check("req_stall", 64'(stall), 64'd1);
      check("req_req", 64'(dmem_req), 64'd1);
      check("req_we", 64'(dmem_we), 64'(wq));
      check("req_addr", 64'(dmem_addr), 64'(alu));
      check("req_wdata", 64'(dmem_wdata), 64'(wd));
      exp_stl++;
      if (w == lat) exp_acc++;
      @(posedge clk); #1;
      check_mwb("req_bubble", 2'd0, 32'd0, 32'd0, 5'd0);
    end
    if (wq) mem[alu] = wd;
    // A spurious ack in DONE must not matter.
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    check("done_stall", 64'(stall), 64'd0);
    check("done_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_mwb("retire", wb, exp_rd, alu, rd);
    check_stats("retire");
  endtask

  initial begin
    rst = 1'b1; wb_in = 2'd0; mem_read = 1'b0; mem_write = 1'b0;
    alu_in = '0; wdata_in = '0; rd_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check_mwb("rst", 2'd0, 32'd0, 32'd0, 5'd0);
    check_stats("rst");
    rst = 1'b0;

    // Directed: nop, load with immediate ack, store with 3 wait cycles.
    mem[32'h40] = 32'hDEAD_BEEF;
    run_op(1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 0);
    run_op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 0);
    run_op(1'b0, 1'b1, 2'b01, 32'h80, 32'hA5A5_A5A5, 5'd9, 3);
`ifdef MEM_STAGE_STATS_EN
    check("s23_acc", 64'(stat_access), 64'd2);
    check("s23_stl", 64'(stat_stall), 64'd7);
`else
    check("s23_acc", 64'(stat_access), 64'd0);
    check("s23_stl", 64'(stat_stall), 64'd0);
`endif
    // Back-to-back loads. The second request may rise only after DONE and a
    // fresh IDLE cycle, and the first load must not be issued twice.
    run_op(1'b1, 1'b0, 2'b11, 32'h80, 32'h0, 5'd3, 1);
    run_op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd4, 0);
    // Both request bits set: behaves as a write.
    run_op(1'b1, 1'b1, 2'b10, 32'h44, 32'h1111_2222, 5'd6, 2);

    // Reset during REQ, then a late ack.
    wb_in = 2'b11; mem_read = 1'b1; mem_write = 1'b0; alu_in = 32'h48; rd_in = 5'd8;
    @(posedge clk); #1;
    check("pre_rst_req", 64'(dmem_req), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_acc = 0; exp_stl = 0;
    wb_in = 2'd0; mem_read = 1'b0; alu_in = '0; rd_in = '0;
    #1;
    check("post_rst_req", 64'(dmem_req), 64'd0);
    check("post_rst_we", 64'(dmem_we), 64'd0);
    check("post_rst_addr", 64'(dmem_addr), 64'd0);
    check("post_rst_stall", 64'(stall), 64'd0);
    check_mwb("post_rst", 2'd0, 32'd0, 32'd0, 5'd0);
    check_stats("post_rst");
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_req", 64'(dmem_req), 64'd0);
    check("late_ack_stall", 64'(stall), 64'd0);
    check_mwb("late_ack", 2'd0, 32'd0, 32'd0, 5'd0);
    check_stats("late_ack");

    // Random mix of ops and latencies over a small address set.
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op(kind[0], kind[1], 2'($urandom), 32'($urandom_range(0, 7)) << 2,
             $urandom, 5'($urandom_range(1, 31)), $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
